// File: rtl/stopwatch_counter_if.sv
// Control inputs and BCD display outputs of the mm:ss stopwatch.
// The slave side is the counter; the master side drives ticks and switches.
interface stopwatch_counter_if;
  logic       tick1;
  logic       tick2;
  logic       ADJ;
  logic       SEL;
  logic       PAUSE;
  logic [2:0] minT;
  logic [3:0] min0;
  logic [2:0] secT;
  logic [3:0] sec0;
  logic       paused;
  logic       adjusting;

  modport slave (
    input  tick1, tick2, ADJ, SEL, PAUSE,
    output minT, min0, secT, sec0, paused, adjusting
  );

  modport master (
    output tick1, tick2, ADJ, SEL, PAUSE,
    input  minT, min0, secT, sec0, paused, adjusting
  );
endinterface

// File: rtl/stopwatch_counter.sv
// BCD mm:ss stopwatch with RUN/HOLD/ADJUST modes; digits update on the edge sampling the tick.
// No backpressure: ticks are single-cycle enables and all outputs come straight from registers.
module stopwatch_counter #(
  parameter bit WRAP_EN = 1'b1
) (
  input  logic                 clk,
  input  logic                 RESET_n,
  stopwatch_counter_if.slave   sw
);

  typedef enum logic [1:0] {RUN, HOLD, ADJUST} state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic       r_pause_q;
  logic       r_paused;
  logic       r_adjusting;
  logic [2:0] r_minT;
  logic [3:0] r_min0;
  logic [2:0] r_secT;
  logic [3:0] r_sec0;

  logic w_pause_rise;
  logic w_paused_nxt;
  logic w_sec_max;
  logic w_min_max;

  assign w_pause_rise = sw.PAUSE & ~r_pause_q;
  assign w_paused_nxt = r_paused ^ w_pause_rise;
  assign w_sec_max    = (r_secT == 3'd5) && (r_sec0 == 4'd9);
  assign w_min_max    = (r_minT == 3'd5) && (r_min0 == 4'd9);

  // Mode changes use the post-toggle pause value so state and flag move together.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      RUN:     if (sw.ADJ) w_state_nxt = ADJUST;
               else if (w_paused_nxt) w_state_nxt = HOLD;
      HOLD:    if (sw.ADJ) w_state_nxt = ADJUST;
               else if (!w_paused_nxt) w_state_nxt = RUN;
      ADJUST:  if (!sw.ADJ) w_state_nxt = w_paused_nxt ? HOLD : RUN;
      default: w_state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!RESET_n) begin
      r_state     <= RUN;
      r_pause_q   <= 1'b0;
      r_paused    <= 1'b0;
      r_adjusting <= 1'b0;
      r_minT      <= 3'd0;
      r_min0      <= 4'd0;
      r_secT      <= 3'd0;
      r_sec0      <= 4'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_pause_q   <= sw.PAUSE;
      r_paused    <= w_paused_nxt;
      r_adjusting <= (w_state_nxt == ADJUST);

      if (r_state == RUN && sw.tick1) begin
        if (w_sec_max && w_min_max) begin
          if (WRAP_EN) begin
            r_minT <= 3'd0;
            r_min0 <= 4'd0;
            r_secT <= 3'd0;
            r_sec0 <= 4'd0;
          end
        end else if (r_sec0 != 4'd9) begin
          r_sec0 <= r_sec0 + 4'd1;
        end else begin
          r_sec0 <= 4'd0;
          if (r_secT != 3'd5) begin
            r_secT <= r_secT + 3'd1;
          end else begin
            r_secT <= 3'd0;
            if (r_min0 != 4'd9) begin
              r_min0 <= r_min0 + 4'd1;
            end else begin
              r_min0 <= 4'd0;
              r_minT <= r_minT + 3'd1;
            end
          end
        end
      end else if (r_state == ADJUST && sw.tick2) begin
        // Each field wraps on its own; no carry between fields while adjusting.
        if (sw.SEL) begin
          if (r_sec0 != 4'd9) begin
            r_sec0 <= r_sec0 + 4'd1;
          end else begin
            r_sec0 <= 4'd0;
            r_secT <= (r_secT == 3'd5) ? 3'd0 : r_secT + 3'd1;
          end
        end else begin
          if (r_min0 != 4'd9) begin
            r_min0 <= r_min0 + 4'd1;
          end else begin
            r_min0 <= 4'd0;
            r_minT <= (r_minT == 3'd5) ? 3'd0 : r_minT + 3'd1;
          end
        end
      end
    end
  end

  assign sw.minT      = r_minT;
  assign sw.min0      = r_min0;
  assign sw.secT      = r_secT;
  assign sw.sec0      = r_sec0;
  assign sw.paused    = r_paused;
  assign sw.adjusting = r_adjusting;

endmodule
